// File: rtl/fp32_pkg.sv
// Shared constants and enumerations for the FP32 -> int32 converter.
package fp32_pkg;

  localparam int WORD_W   = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIG_W    = 24;
  localparam int CNT_W    = 5;
  localparam int SIGN_POS = 31;
  localparam int EXP_LSB  = 23;

  localparam logic [EXP_W-1:0] EXP_BIAS       = 8'd127;
  localparam logic [EXP_W-1:0] INT_SHIFT_BASE = 8'd150;
  localparam logic [EXP_W-1:0] INT_OVF_EXP    = 8'd158;
  localparam logic [EXP_W-1:0] EXP_SPECIAL    = 8'd255;

  localparam logic signed [WORD_W-1:0] INT32_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [WORD_W-1:0] INT32_MIN = 32'sh8000_0000;

  // -2^31 is the only float with exponent >= 158 that is representable.
  localparam logic [WORD_W-1:0] FP_INT32_MIN = 32'hCF00_0000;

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, NEG, DONE} state_e;

  typedef enum logic [2:0] {ZERO, TINY, NORMAL, SAT, NAN} fp_class_e;

endpackage

// File: rtl/fp32_to_int_if.sv
// Handshake bundle between the FP datapath, the converter and integer logic.
interface fp32_to_int_if;
  import fp32_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              invalid;
  logic              inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, invalid, inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, invalid, inexact
  );

endinterface

// File: rtl/fp32_classify.sv
// Combinational operand classifier: class, shift direction and distance.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output fp_class_e         cls,
  output logic              shift_left,
  output logic [CNT_W-1:0]  shift_dist,
  output logic              sat_exact
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;

  assign e = word[SIGN_POS-1:EXP_LSB];
  assign m = word[MAN_W-1:0];

  // Decode exponent ranges into a class and the shift that aligns the binary point
  always_comb begin
    cls        = NORMAL;
    shift_left = 1'b0;
    shift_dist = '0;
    sat_exact  = 1'b0;
    if (e == EXP_SPECIAL) begin
      cls = (m != '0) ? NAN : SAT;
    end else if (e >= INT_OVF_EXP) begin
      cls       = SAT;
      sat_exact = (word == FP_INT32_MIN);
    end else if (e == '0 && m == '0) begin
      cls = ZERO;
    end else if (e < EXP_BIAS) begin
      cls = TINY;
    end else if (e <= INT_SHIFT_BASE) begin
      shift_dist = CNT_W'(INT_SHIFT_BASE - e);
    end else begin
      shift_left = 1'b1;
      shift_dist = CNT_W'(e - INT_SHIFT_BASE);
    end
  end

endmodule

// File: rtl/fp32_to_int.sv
// Iterative FP32 -> signed int32 converter, round toward zero, saturating.
// Non-normal operands still pass through NEG so that every zero-shift
// conversion has the same latency.
module fp32_to_int
  import fp32_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input logic         clk,
  input logic         rst,
  fp32_to_int_if.slave bus
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

  state_e                    state_q, state_d;
  logic [WORD_W-1:0]         word_q;
  logic [WORD_W-1:0]         mag_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      left_q, sign_q, sticky_q, inv_q, normal_q;
  logic signed [WORD_W-1:0]  res_q;
  logic                      invalid_q, inexact_q;

  fp_class_e                 cls;
  logic                      shift_left, sat_exact;
  logic [CNT_W-1:0]          shift_dist;
  logic [CNT_W-1:0]          step;
  logic [WORD_W-1:0]         lost_mask;

  function automatic logic signed [WORD_W-1:0] sat_value(input logic neg);
    return neg ? INT32_MIN : INT32_MAX;
  endfunction

  function automatic logic signed [WORD_W-1:0] apply_sign(input logic [WORD_W-1:0] mag,
                                                          input logic neg);
    logic signed [WORD_W-1:0] v;
    v = signed'(mag);
    return neg ? -v : v;
  endfunction

  fp32_classify u_classify (
    .word       (word_q),
    .cls        (cls),
    .shift_left (shift_left),
    .shift_dist (shift_dist),
    .sat_exact  (sat_exact)
  );

  assign step      = (cnt_q > STEP) ? STEP : cnt_q;
  assign lost_mask = (32'h1 << step) - 32'h1;

  // State register; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = UNPACK;
      UNPACK:  state_d = (cls == NORMAL && shift_dist != '0) ? SHIFT : NEG;
      SHIFT:   if (cnt_q <= STEP) state_d = NEG;
      NEG:     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working datapath: latch, unpack, iterative shift with sticky collection
  always_ff @(posedge clk) begin
    unique case (state_q)
      IDLE: if (bus.in_valid) word_q <= bus.in_data;
      UNPACK: begin
        sign_q   <= word_q[SIGN_POS];
        left_q   <= shift_left;
        cnt_q    <= shift_dist;
        normal_q <= (cls == NORMAL);
        sticky_q <= 1'b0;
        inv_q    <= 1'b0;
        case (cls)
          NORMAL:  mag_q <= {{(WORD_W-SIG_W){1'b0}}, 1'b1, word_q[MAN_W-1:0]};
          TINY:    begin mag_q <= '0; sticky_q <= 1'b1; end
          SAT:     begin mag_q <= sat_value(word_q[SIGN_POS]); inv_q <= ~sat_exact; end
          NAN:     begin mag_q <= INT32_MAX; inv_q <= 1'b1; end
          default: mag_q <= '0;
        endcase
      end
      SHIFT: begin
        cnt_q <= cnt_q - step;
        if (left_q) begin
          mag_q <= mag_q << step;
        end else begin
          mag_q    <= mag_q >> step;
          sticky_q <= sticky_q | (|(mag_q & lost_mask));
        end
      end
      default: ;
    endcase
  end

  // Result registers: loaded once in NEG, held stable through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else if (state_q == NEG) begin
      res_q     <= normal_q ? apply_sign(mag_q, sign_q) : signed'(mag_q);
      invalid_q <= inv_q;
      inexact_q <= sticky_q;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = res_q;
  assign bus.invalid   = invalid_q;
  assign bus.inexact   = inexact_q;

endmodule

// File: tb/tb_fp32_to_int.sv
// Directed bench for fp32_to_int with SHIFT_STEP = 8.
module tb_fp32_to_int;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fp32_to_int_if bus();

  fp32_to_int #(.SHIFT_STEP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Send one word, measure edges from acceptance to out_valid, check result,
  // optionally hold out_ready low for `hold` cycles, then complete handshake.
  task automatic run(input string tag, input logic [31:0] w, input logic [31:0] exp_d,
                     input logic exp_inv, input logic exp_inx, input int exp_lat,
                     input int hold);
    int n;
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(exp_lat));
    check({tag, "/data"}, bus.out_data, exp_d);
    check({tag, "/invalid"}, 32'(bus.invalid), 32'(exp_inv));
    check({tag, "/inexact"}, 32'(bus.inexact), 32'(exp_inx));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "/hold_data"}, bus.out_data, exp_d);
      check({tag, "/hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "/release_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "/release_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst/in_ready", 32'(bus.in_ready), 32'd1);
    check("rst/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst/data", bus.out_data, 32'h0);
    check("rst/flags", {30'd0, bus.invalid, bus.inexact}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Normal right shifts
    run("one",      32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 5, 0);
    run("m2p5",     32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 5, 0);
    run("one_p5",   32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 5, 0);
    run("m_one",    32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5, 0);
    run("rsh8",     32'h4700_0001, 32'h0000_8000, 1'b0, 1'b1, 3, 0);
    run("rsh9",     32'h4680_0000, 32'h0000_4000, 1'b0, 1'b0, 4, 0);
    // No shift and left shifts
    run("noshift",  32'h4B00_0005, 32'h0080_0005, 1'b0, 1'b0, 2, 0);
    run("lsh1_neg", 32'hCB80_0001, 32'hFEFF_FFFE, 1'b0, 1'b0, 3, 0);
    run("two30",    32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 3, 0);
    run("max_pos",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 3, 0);
    run("max_neg",  32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 3, 0);
    // Saturation and specials
    run("ovf_pos",  32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 0);
    run("int_min",  32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2, 0);
    run("ovf_neg",  32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 2, 0);
    run("pos_inf",  32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 0);
    run("neg_inf",  32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2, 0);
    // Zero and tiny values
    run("neg_zero", 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2, 0);
    run("half",     32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 2, 0);
    run("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2, 0);
    // Backpressure
    run("bp_one",   32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 5, 5);
    // Leave nonzero outputs and flags before the reset test
    run("nan",      32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 0);

    // Reset while in SHIFT
    @(negedge clk);
    bus.in_data  = 32'h3F80_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst/in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst/out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst/data", bus.out_data, 32'h0);
    check("mid_rst/invalid", 32'(bus.invalid), 32'd0);
    check("mid_rst/inexact", 32'(bus.inexact), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
